core0_bus_responder: RTL and testbench

//  Far-end partner for one core0 sender bus: answers the kill/incept/send/stream request lines a core

---
 rtl/core0_bus_pkg.sv | 33 +++
 rtl/core0_sync_fifo.sv | 70 +++++++
 rtl/core0_bus_responder.sv | 132 +++++++++++++
 tb/tb_core0_bus_responder.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core0_bus_pkg.sv
// Shared types for the core0 sender-bus responder: request kinds, responder FSM states and
// the bit positions of the one-hot ack register.
package core0_bus_pkg;

    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_KILL,
        REQ_INCEPT,
        REQ_SEND,
        REQ_STREAM
    } req_kind_t;

    typedef enum logic {
        RSP_IDLE,
        RSP_ACK
    } rsp_state_t;

    localparam int unsigned ACK_KILL   = 0;
    localparam int unsigned ACK_INCEPT = 1;
    localparam int unsigned ACK_SEND   = 2;
    localparam int unsigned ACK_STREAM = 3;

    // Fixed priority: kill > incept > send > stream.
    function automatic req_kind_t pick_req(input logic kill, input logic incept,
                                           input logic send, input logic stream);
        if (kill)        return REQ_KILL;
        else if (incept) return REQ_INCEPT;
        else if (send)   return REQ_SEND;
        else if (stream) return REQ_STREAM;
        else             return REQ_NONE;
    endfunction

endpackage

// File: rtl/core0_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a flush that overrides push and pop.
// A pop on a full FIFO frees a slot for a push on the same edge.
module core0_sync_fifo #(
    parameter int unsigned WIDTH      = 33,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      head_data_o,
    output logic                  head_valid_o,
    output logic                  full_o,
    output logic [ADDR_WIDTH:0]   count_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign head_valid_o = (count_q != '0);
    assign full_o       = count_q[ADDR_WIDTH];
    assign count_o      = count_q;
    assign head_data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & head_valid_o & ~flush_i;
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
                2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/core0_bus_responder.sv
// Far-end responder for one core0 sender bus: arbitrates kill/incept/send/stream requests,
// returns one-cycle acks, queues payload words and holds the captured incept.
module core0_bus_responder
    import core0_bus_pkg::*;
#(
    parameter  int unsigned WORD_MAG        = 5,
    parameter  int unsigned FIFO_ADDR_WIDTH = 3,
    localparam int unsigned WORD_WIDTH      = 1 << WORD_MAG
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     enable_i,
    input  logic                     global_kill_i,
    input  logic                     global_incept_i,
    input  logic                     global_send_i,
    input  logic                     global_stream_i,
    input  logic [WORD_WIDTH-1:0]    global_data_i,
    input  logic [WORD_WIDTH-1:0]    global_incept_permission_i,
    input  logic [WORD_WIDTH-1:0]    global_incept_address_i,
    output logic                     kill_ack_o,
    output logic                     incept_ack_o,
    output logic                     send_ack_o,
    output logic                     stream_ack_o,
    output logic                     out_valid_o,
    output logic [WORD_WIDTH-1:0]    out_data_o,
    output logic                     out_is_stream_o,
    input  logic                     out_ready_i,
    output logic [FIFO_ADDR_WIDTH:0] fifo_count_o,
    output logic                     incept_valid_o,
    output logic [WORD_WIDTH-1:0]    incept_permission_o,
    output logic [WORD_WIDTH-1:0]    incept_address_o,
    input  logic                     incept_clear_i
);

    rsp_state_t            state_q, state_d;
    req_kind_t             req;
    logic [3:0]            ack_q, ack_d;
    logic                  incept_valid_q, incept_valid_d;
    logic [WORD_WIDTH-1:0] perm_q, perm_d;
    logic [WORD_WIDTH-1:0] addr_q, addr_d;
    logic                  fifo_push, fifo_pop, fifo_flush, fifo_full;
    logic [WORD_WIDTH:0]   fifo_head;

    assign req = enable_i ? pick_req(global_kill_i, global_incept_i, global_send_i,
                                     global_stream_i) : REQ_NONE;
    assign fifo_pop = out_valid_o & out_ready_i;

    always_comb begin
        state_d        = state_q;
        ack_d          = '0;
        fifo_push      = 1'b0;
        fifo_flush     = 1'b0;
        incept_valid_d = incept_valid_q & ~incept_clear_i;
        perm_d         = perm_q;
        addr_d         = addr_q;
        case (state_q)
            RSP_IDLE: begin
                unique case (req)
                    REQ_KILL: begin
                        ack_d[ACK_KILL] = 1'b1;
                        fifo_flush      = 1'b1;
                        incept_valid_d  = 1'b0;
                        state_d         = RSP_ACK;
                    end
                    REQ_INCEPT: begin
                        if (!incept_valid_q || incept_clear_i) begin
                            ack_d[ACK_INCEPT] = 1'b1;
                            incept_valid_d    = 1'b1;
                            perm_d            = global_incept_permission_i;
                            addr_d            = global_incept_address_i;
                            state_d           = RSP_ACK;
                        end
                    end
                    REQ_SEND, REQ_STREAM: begin
                        // A same-edge pop frees the slot this push needs.
                        if (!fifo_full || fifo_pop) begin
                            ack_d[ACK_SEND]   = (req == REQ_SEND);
                            ack_d[ACK_STREAM] = (req == REQ_STREAM);
                            fifo_push         = 1'b1;
                            state_d           = RSP_ACK;
                        end
                    end
                    default: ;
                endcase
            end
            default: state_d = RSP_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q        <= RSP_IDLE;
            ack_q          <= '0;
            incept_valid_q <= 1'b0;
            perm_q         <= '0;
            addr_q         <= '0;
        end else begin
            state_q        <= state_d;
            ack_q          <= ack_d;
            incept_valid_q <= incept_valid_d;
            perm_q         <= perm_d;
            addr_q         <= addr_d;
        end
    end

    core0_sync_fifo #(
        .WIDTH      (WORD_WIDTH + 1),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .flush_i      (fifo_flush),
        .push_i       (fifo_push),
        .push_data_i  ({req == REQ_STREAM, global_data_i}),
        .pop_i        (fifo_pop),
        .head_data_o  (fifo_head),
        .head_valid_o (out_valid_o),
        .full_o       (fifo_full),
        .count_o      (fifo_count_o)
    );

    assign out_is_stream_o     = fifo_head[WORD_WIDTH];
    assign out_data_o          = fifo_head[WORD_WIDTH-1:0];
    assign kill_ack_o          = ack_q[ACK_KILL];
    assign incept_ack_o        = ack_q[ACK_INCEPT];
    assign send_ack_o          = ack_q[ACK_SEND];
    assign stream_ack_o        = ack_q[ACK_STREAM];
    assign incept_valid_o      = incept_valid_q;
    assign incept_permission_o = perm_q;
    assign incept_address_o    = addr_q;

endmodule

// File: tb/tb_core0_bus_responder.sv
// Scoreboard bench for core0_bus_responder: queued words are predicted on ack and compared
// as the consumer pops them; ack timing, priority, incept and reset behaviour checked inline.
module tb_core0_bus_responder;

    localparam int K_KILL = 0, K_INCEPT = 1, K_SEND = 2, K_STREAM = 3;

    logic        clk = 1'b0;
    logic        reset_n, enable, kill, incept, send, stream, out_ready, incept_clear;
    logic [31:0] data, iperm, iaddr;
    logic        kill_ack, incept_ack, send_ack, stream_ack, out_valid, out_is_stream;
    logic        incept_valid;
    logic [31:0] out_data, incept_permission, incept_address;
    logic [3:0]  fifo_count;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    core0_bus_responder dut (
        .clk_i                      (clk),
        .reset_ni                   (reset_n),
        .enable_i                   (enable),
        .global_kill_i              (kill),
        .global_incept_i            (incept),
        .global_send_i              (send),
        .global_stream_i            (stream),
        .global_data_i              (data),
        .global_incept_permission_i (iperm),
        .global_incept_address_i    (iaddr),
        .kill_ack_o                 (kill_ack),
        .incept_ack_o               (incept_ack),
        .send_ack_o                 (send_ack),
        .stream_ack_o               (stream_ack),
        .out_valid_o                (out_valid),
        .out_data_o                 (out_data),
        .out_is_stream_o            (out_is_stream),
        .out_ready_i                (out_ready),
        .fifo_count_o               (fifo_count),
        .incept_valid_o             (incept_valid),
        .incept_permission_o        (incept_permission),
        .incept_address_o           (incept_address),
        .incept_clear_i             (incept_clear)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raises one request line and waits up to limit edges for its ack; drops it only if acked.
    task automatic do_req(input int kind, input int limit, output bit got);
        got = 1'b0;
        case (kind)
            K_KILL:   kill = 1'b1;
            K_INCEPT: incept = 1'b1;
            K_SEND:   send = 1'b1;
            default:  stream = 1'b1;
        endcase
        for (int c = 0; c < limit && !got; c++) begin
            step();
            case (kind)
                K_KILL:   got = kill_ack;
                K_INCEPT: got = incept_ack;
                K_SEND:   got = send_ack;
                default:  got = stream_ack;
            endcase
        end
        if (got) begin
            kill = 1'b0; incept = 1'b0; send = 1'b0; stream = 1'b0;
        end
    endtask

    task automatic test_drain();
        int limit = 40;
        out_ready = 1'b1;
        while (sb.size() > 0 && limit > 0) begin
            checks++;
            if (!out_valid) begin
                errors++;
                $display("FAIL drain_valid: out_valid=0 with %0d words expected", sb.size());
                sb.delete();
            end else begin
                if ({out_is_stream, out_data} !== sb[0]) begin
                    errors++;
                    $display("FAIL drain_word: got %h want %h", {out_is_stream, out_data}, sb[0]);
                end
                void'(sb.pop_front());
                step();
            end
            limit--;
        end
        out_ready = 1'b0;
        checks++;
        if (fifo_count !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: count=%0d valid=%b want 0/0", fifo_count, out_valid);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; send = 1'b1; data = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({kill_ack, incept_ack, send_ack, stream_ack, out_valid} !== 5'b0 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: acks/valid=%b count=%0d want 0", 
                     {kill_ack, incept_ack, send_ack, stream_ack, out_valid}, fifo_count);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (send_ack !== 1'b0 || fifo_count !== 4'd0 || incept_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: send_ack=%b count=%0d ival=%b want 0", send_ack, fifo_count,
                     incept_valid);
        end
        send = 1'b0;
        step();
    endtask

    task automatic test_send();
        send = 1'b1; data = 32'h8000_0001;
        step();
        checks++;
        if (send_ack !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h8000_0001 ||
            out_is_stream !== 1'b0 || fifo_count !== 4'd1) begin
            errors++;
            $display("FAIL send_accept: ack=%b valid=%b data=%h strm=%b cnt=%0d want 1 1 80000001 0 1",
                     send_ack, out_valid, out_data, out_is_stream, fifo_count);
        end
        sb.push_back({1'b0, 32'h8000_0001});
        step();
        checks++;
        if (send_ack !== 1'b0 || fifo_count !== 4'd1) begin
            errors++;
            $display("FAIL send_once: ack=%b count=%0d want 0 1", send_ack, fifo_count);
        end
        send = 1'b0;
        step();
        test_drain();
    endtask

    task automatic test_enable();
        enable = 1'b0; send = 1'b1; data = 32'h77;
        repeat (3) begin
            step();
            checks++;
            if (send_ack !== 1'b0 || fifo_count !== 4'd0) begin
                errors++;
                $display("FAIL enable_gate: ack=%b count=%0d want 0 0", send_ack, fifo_count);
            end
        end
        send = 1'b0; enable = 1'b1;
    endtask

    task automatic test_full();
        bit got;
        int acks = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            data = 32'h1000 + i;
            do_req(K_SEND, 6, got);
            if (got) begin
                acks++;
                sb.push_back({1'b0, 32'h1000 + i});
            end
        end
        checks++;
        if (acks != 8 || fifo_count !== 4'd8) begin
            errors++;
            $display("FAIL full_fill: acks=%0d count=%0d want 8 8", acks, fifo_count);
        end
        data = 32'hF00D_0009;
        do_req(K_SEND, 4, got);
        checks++;
        if (got) begin
            errors++;
            $display("FAIL full_stall: 9th send acked=1 want 0");
            sb.push_back({1'b0, 32'hF00D_0009});
        end else begin
            checks++;
            if ({out_is_stream, out_data} !== sb[0]) begin
                errors++;
                $display("FAIL full_head: got %h want %h", {out_is_stream, out_data}, sb[0]);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            void'(sb.pop_front());
            checks++;
            if (send_ack !== 1'b1 || fifo_count !== 4'd8) begin
                errors++;
                $display("FAIL full_pushpop: ack=%b count=%0d want 1 8", send_ack, fifo_count);
            end
            sb.push_back({1'b0, 32'hF00D_0009});
        end
        send = 1'b0;
        test_drain();
    endtask

    task automatic test_priority();
        bit got;
        iperm = 32'h1; iaddr = 32'h2;
        do_req(K_INCEPT, 4, got);
        for (int i = 0; i < 3; i++) begin
            data = 32'h2000 + i;
            do_req(K_SEND, 6, got);
        end
        checks++;
        if (fifo_count !== 4'd3 || incept_valid !== 1'b1) begin
            errors++;
            $display("FAIL prio_setup: count=%0d ival=%b want 3 1", fifo_count, incept_valid);
        end
        step();
        kill = 1'b1; send = 1'b1; incept = 1'b1;
        step();
        checks++;
        if ({kill_ack, incept_ack, send_ack, stream_ack} !== 4'b1000 || fifo_count !== 4'd0 ||
            out_valid !== 1'b0 || incept_valid !== 1'b0) begin
            errors++;
            $display("FAIL prio_kill: acks=%b count=%0d valid=%b ival=%b want 1000 0 0 0",
                     {kill_ack, incept_ack, send_ack, stream_ack}, fifo_count, out_valid,
                     incept_valid);
        end
        kill = 1'b0; send = 1'b0; incept = 1'b0;
        sb.delete();
        step();
        checks++;
        if (kill_ack !== 1'b0 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL prio_after: kill_ack=%b count=%0d want 0 0", kill_ack, fifo_count);
        end
    endtask

    task automatic test_incept();
        bit got;
        iperm = 32'hA5; iaddr = 32'h40;
        do_req(K_INCEPT, 4, got);
        checks++;
        if (!got || incept_valid !== 1'b1 || incept_permission !== 32'hA5 ||
            incept_address !== 32'h40) begin
            errors++;
            $display("FAIL incept_first: ack=%b ival=%b perm=%h addr=%h want 1 1 a5 40", got,
                     incept_valid, incept_permission, incept_address);
        end
        iperm = 32'h5A; iaddr = 32'h80;
        do_req(K_INCEPT, 4, got);
        checks++;
        if (got || incept_permission !== 32'hA5) begin
            errors++;
            $display("FAIL incept_stall: ack=%b perm=%h want 0 a5", got, incept_permission);
        end
        incept_clear = 1'b1;
        step();
        incept_clear = 1'b0;
        checks++;
        if (incept_ack !== 1'b1 || incept_valid !== 1'b1 || incept_permission !== 32'h5A ||
            incept_address !== 32'h80) begin
            errors++;
            $display("FAIL incept_clear_take: ack=%b ival=%b perm=%h addr=%h want 1 1 5a 80",
                     incept_ack, incept_valid, incept_permission, incept_address);
        end
        incept = 1'b0;
        incept_clear = 1'b1;
        step();
        checks++;
        if (incept_valid !== 1'b0) begin
            errors++;
            $display("FAIL incept_release: ival=%b want 0", incept_valid);
        end
        step();
        incept_clear = 1'b0;
        checks++;
        if (incept_valid !== 1'b0 || incept_ack !== 1'b0) begin
            errors++;
            $display("FAIL incept_idle_clear: ival=%b ack=%b want 0 0", incept_valid, incept_ack);
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        logic [31:0] d = 32'h3000_0000;
        stream = 1'b1; data = d;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (stream_ack !== ((k % 2) == 0)) begin
                errors++;
                $display("FAIL b2b_ack[%0d]: got %b want %b", k, stream_ack, (k % 2) == 0);
            end
            if (stream_ack) begin
                acks++;
                sb.push_back({1'b1, d});
                d = d + 32'h11;
                data = d;
            end
        end
        stream = 1'b0;
        checks++;
        if (acks != 3 || fifo_count !== 4'd3) begin
            errors++;
            $display("FAIL b2b_count: acks=%0d count=%0d want 3 3", acks, fifo_count);
        end
        test_drain();
    endtask

    task automatic test_async_reset();
        stream = 1'b1; data = 32'hDEAD_BEEF;
        step();
        stream = 1'b0;
        checks++;
        if (stream_ack !== 1'b1 || out_is_stream !== 1'b1 || out_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL areset_pre: ack=%b strm=%b data=%h want 1 1 deadbeef", stream_ack,
                     out_is_stream, out_data);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (stream_ack !== 1'b0 || out_valid !== 1'b0 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL areset_mid_ack: ack=%b valid=%b count=%0d want 0 0 0", stream_ack,
                     out_valid, fifo_count);
        end
        sb.delete();
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if (stream_ack !== 1'b0 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL areset_after: ack=%b count=%0d want 0 0", stream_ack, fifo_count);
        end
    endtask

    initial begin
        kill = 1'b0; incept = 1'b0; send = 1'b0; stream = 1'b0;
        out_ready = 1'b0; incept_clear = 1'b0;
        iperm = '0; iaddr = '0; data = '0; enable = 1'b0; reset_n = 1'b0;
        test_reset();
        test_send();
        test_enable();
        test_full();
        test_priority();
        test_incept();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
